// File: rtl/riscv_pkg.sv
// Shared types for the issue stage: register file geometry, scoreboard FSM states
// and the decoded-instruction fields carried through the single issue slot.
package riscv_pkg;

  localparam int NUM_REGS = 32;
  localparam int RIDX_W   = 5;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    CSR_BUSY = 2'd2
  } sb_state_e;

  // Field order matters only for packing; the first field lands in the MSBs.
  typedef struct packed {
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic              rd_en;
    logic              r1_en;
    logic              r2_en;
    logic              csrr_en;
  } sb_instr_t;

endpackage

// File: rtl/sb_hazard_check.sv
// Combinational RAW/WAW hazard test of one instruction against the pending-write
// vector. Register index 0 never hazards because x0 is never written.
module sb_hazard_check
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  sb_instr_t           instr,
  input  logic [NUM_REGS-1:0] busy,
  output logic                hazard
);

  logic raw1;
  logic raw2;
  logic waw;

  always_comb begin
    raw1   = instr.r1_en && (instr.rs1 != '0) && busy[instr.rs1];
    raw2   = instr.r2_en && (instr.rs2 != '0) && busy[instr.rs2];
    waw    = instr.rd_en && (instr.rd  != '0) && busy[instr.rd];
    hazard = raw1 || raw2 || waw;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Single-entry issue slot with a per-register pending-write scoreboard. Stalls on
// RAW/WAW hazards and serialises CSR instructions (drain, issue, wait for writeback).
module issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int RIDX_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [RIDX_W-1:0]   dec_rd,
  input  logic [RIDX_W-1:0]   dec_rs1,
  input  logic [RIDX_W-1:0]   dec_rs2,
  input  logic                dec_rd_en,
  input  logic                dec_r1_en,
  input  logic                dec_r2_en,
  input  logic                dec_csrr_en,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [RIDX_W-1:0]   iss_rd,
  output logic [RIDX_W-1:0]   iss_rs1,
  output logic [RIDX_W-1:0]   iss_rs2,
  output logic                iss_rd_en,
  output logic                iss_r1_en,
  output logic                iss_r2_en,
  output logic                iss_csrr_en,
  input  logic                wb_valid,
  input  logic [RIDX_W-1:0]   wb_rd,
  input  logic                wb_csr,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    stall_cnt,
  output sb_state_e           dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid && ready are both high.
  // A producer holding valid keeps its payload stable and never withdraws valid
  // until the transfer, except through flush or reset.

  sb_instr_t           slot_q, slot_d;
  sb_instr_t           dec_instr;
  logic                slot_valid_q, slot_valid_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  sb_state_e           state_q, state_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic busy_any;
  logic issue_fire;
  logic accept;

  always_comb begin
    dec_instr         = '0;
    dec_instr.rd      = dec_rd;
    dec_instr.rs1     = dec_rs1;
    dec_instr.rs2     = dec_rs2;
    dec_instr.rd_en   = dec_rd_en;
    dec_instr.r1_en   = dec_r1_en;
    dec_instr.r2_en   = dec_r2_en;
    dec_instr.csrr_en = dec_csrr_en;
  end

  sb_hazard_check #(
    .NUM_REGS (NUM_REGS)
  ) u_hazard (
    .instr  (slot_q),
    .busy   (busy_q),
    .hazard (hazard)
  );

  assign busy_any = |busy_q;

  // A CSR only issues from DRAIN, once every older write has retired.
  always_comb begin
    iss_valid = 1'b0;
    unique case (state_q)
      RUN:      iss_valid = slot_valid_q && !hazard && !slot_q.csrr_en;
      DRAIN:    iss_valid = slot_valid_q && !busy_any;
      CSR_BUSY: iss_valid = 1'b0;
      default:  iss_valid = 1'b0;
    endcase
  end

  assign issue_fire = iss_valid && iss_ready;
  assign dec_ready  = rst_n && !flush && (!slot_valid_q || issue_fire);
  assign accept     = dec_valid && dec_ready;

  always_comb begin
    slot_d       = slot_q;
    slot_valid_d = slot_valid_q;
    if (flush) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_d       = dec_instr;
      slot_valid_d = 1'b1;
    end else if (issue_fire) begin
      slot_valid_d = 1'b0;
    end
  end

  // Set after clear so an issue to the same register as a writeback wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid && (wb_rd != '0)) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (issue_fire && slot_q.rd_en && (slot_q.rd != '0)) begin
      busy_d[slot_q.rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (slot_valid_q && slot_q.csrr_en && !flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (issue_fire)  state_d = CSR_BUSY;
        else if (flush)  state_d = RUN;
      end
      CSR_BUSY: begin
        if (wb_valid && wb_csr) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (slot_valid_q && !iss_valid && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      busy_q       <= '0;
      state_q      <= RUN;
      stall_cnt_q  <= '0;
    end else begin
      slot_q       <= slot_d;
      slot_valid_q <= slot_valid_d;
      busy_q       <= busy_d;
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign iss_rd      = slot_q.rd;
  assign iss_rs1     = slot_q.rs1;
  assign iss_rs2     = slot_q.rs2;
  assign iss_rd_en   = slot_q.rd_en;
  assign iss_r1_en   = slot_q.r1_en;
  assign iss_r2_en   = slot_q.r2_en;
  assign iss_csrr_en = slot_q.csrr_en;
  assign busy        = busy_q;
  assign stall_cnt   = stall_cnt_q;
  assign dbg_state   = state_q;

endmodule
